// File: rtl/pi_seq_if.sv
// pi_seq_if: bundles the A2D conversion handshake and the ALU operand/control
// bus between the PI sequencer (master) and the alu/A2D side (slave).
interface pi_seq_if;
   // A2D handshake
   logic        strt_cnv;
   logic        cnv_cmplt;
   logic [11:0] a2d_in;

   // ALU result fed back to the sequencer
   logic [15:0] dst;

   // Registered ALU operands
   logic [15:0] Accum;
   logic [15:0] Pcomp;
   logic [11:0] Icomp;
   logic [13:0] Pterm;
   logic [11:0] Iterm;
   logic [11:0] Fwd;
   logic [11:0] A2D_res;
   logic [11:0] Error;
   logic [11:0] Intgrl;

   // ALU source selects and function flags
   logic [2:0]  src0sel;
   logic [2:0]  src1sel;
   logic        multiply;
   logic        sub;
   logic        mult2;
   logic        mult4;
   logic        saturate;

   modport master (
      input  cnv_cmplt, a2d_in, dst,
      output strt_cnv, Accum, Pcomp, Icomp, Pterm, Iterm, Fwd, A2D_res, Error,
             Intgrl, src0sel, src1sel, multiply, sub, mult2, mult4, saturate
   );

   modport slave (
      output cnv_cmplt, a2d_in, dst,
      input  strt_cnv, Accum, Pcomp, Icomp, Pterm, Iterm, Fwd, A2D_res, Error,
             Intgrl, src0sel, src1sel, multiply, sub, mult2, mult4, saturate
   );
endinterface

// File: rtl/pi_seq.sv
// pi_seq: control sequencer for the PI motor loop. Each iteration runs one A2D
// conversion and six single-cycle ALU steps, then updates mtr_cmd.
// Optional feature macro: ANTI_WINDUP_EN (integrator write suppressed while the
// last motor command sat on a 12-bit rail).
module pi_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [11:0] setpoint,
   input  logic [13:0] pterm_in,
   input  logic [11:0] iterm_in,
   input  logic [11:0] fwd_in,
   output logic        busy,
   output logic        done,
   output logic [11:0] mtr_cmd,
   pi_seq_if.master    bus
);

   typedef enum logic [3:0] {
      IDLE, CNV_REQ, CNV_WAIT, ERR, INTG, ICOMP, PCOMP, ACC1, ACC2, DONE
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] dec_cnt;
   logic       intg_wr;

`ifdef ANTI_WINDUP_EN
   logic sat_flag;

   // Remember whether the last motor command landed on a rail.
   always_ff @(posedge clk) begin
      if (rst)
         sat_flag <= 1'b0;
      else if (state == ACC2)
         sat_flag <= (bus.dst[11:0] == 12'h7FF) || (bus.dst[11:0] == 12'h800);
   end

   assign intg_wr = (dec_cnt == 2'd3) && !sat_flag;
`else
   assign intg_wr = (dec_cnt == 2'd3);
`endif

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and per-state ALU controls.
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves a latch.
      state_nxt    = state;
      bus.strt_cnv = 1'b0;
      bus.src0sel  = 3'b000;
      bus.src1sel  = 3'b000;
      bus.multiply = 1'b0;
      bus.sub      = 1'b0;
      bus.mult2    = 1'b0;
      bus.saturate = 1'b0;
      done         = 1'b0;
      case (state)
         IDLE:     if (start) state_nxt = CNV_REQ;
         CNV_REQ:  begin
            bus.strt_cnv = 1'b1;
            state_nxt    = CNV_WAIT;
         end
         CNV_WAIT: if (bus.cnv_cmplt) state_nxt = ERR;
         ERR:      begin
            bus.sub      = 1'b1;
            bus.saturate = 1'b1;
            state_nxt    = INTG;
         end
         INTG:     begin
            bus.src0sel  = 3'b001;
            bus.src1sel  = 3'b011;
            bus.saturate = 1'b1;
            state_nxt    = ICOMP;
         end
         ICOMP:    begin
            bus.src0sel  = 3'b001;
            bus.src1sel  = 3'b001;
            bus.multiply = 1'b1;
            state_nxt    = PCOMP;
         end
         PCOMP:    begin
            bus.src0sel  = 3'b100;
            bus.src1sel  = 3'b010;
            bus.multiply = 1'b1;
            state_nxt    = ACC1;
         end
         ACC1:     begin
            bus.src0sel  = 3'b011;
            bus.src1sel  = 3'b100;
            bus.saturate = 1'b1;
            state_nxt    = ACC2;
         end
         ACC2:     begin
            bus.src0sel  = 3'b010;
            bus.mult2    = 1'b1;
            bus.saturate = 1'b1;
            state_nxt    = DONE;
         end
         DONE:     begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default:  state_nxt = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign bus.mult4 = 1'b0;

   // Operand registers, motor command and decimation counter.
   always_ff @(posedge clk) begin
      // NOTE: the operand file is a handful of flops, not a RAM, so all of it
      // is reset and the first iteration starts from known zeros.
      if (rst) begin
         bus.Accum   <= '0;
         bus.Pcomp   <= '0;
         bus.Icomp   <= '0;
         bus.Pterm   <= '0;
         bus.Iterm   <= '0;
         bus.Fwd     <= '0;
         bus.A2D_res <= '0;
         bus.Error   <= '0;
         bus.Intgrl  <= '0;
         mtr_cmd     <= '0;
         dec_cnt     <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               bus.Accum <= {4'h0, setpoint};
               bus.Pterm <= pterm_in;
               bus.Iterm <= iterm_in;
               bus.Fwd   <= fwd_in;
            end
            CNV_WAIT: if (bus.cnv_cmplt) bus.A2D_res <= bus.a2d_in;
            ERR:      bus.Error <= bus.dst[11:0];
            INTG:     if (intg_wr) bus.Intgrl <= bus.dst[11:0];
            ICOMP:    bus.Icomp <= bus.dst[11:0];
            PCOMP:    bus.Pcomp <= bus.dst;
            ACC1:     bus.Accum <= bus.dst;
            ACC2:     begin
               bus.Accum <= bus.dst;
               mtr_cmd   <= bus.dst[11:0];
               dec_cnt   <= dec_cnt + 2'd1;
            end
            default:  ;
         endcase
      end
   end

endmodule

// File: doc/pi_seq.md
# pi_seq

Control sequencer for the PI motor loop. Owns the operand registers that feed the combinational `alu` datapath, drives its `src0sel`/`src1sel`/flag controls and writes `dst` back into the register file. Each control iteration runs one A2D conversion handshake and six ALU steps, then produces a 12-bit motor command. Sits directly upstream and downstream of `alu`: it feeds every ALU input and consumes `dst`.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request one control iteration; sampled only in IDLE
- `setpoint`  in  12  target value, latched on accepted `start`
- `pterm_in`, `iterm_in`, `fwd_in`  in  14/12/12  gains and feed-forward, latched on accepted `start`
- `strt_cnv`  out  1  one-cycle A2D conversion request
- `cnv_cmplt`  in  1  A2D result valid on `a2d_in`
- `a2d_in`  in  12  A2D conversion result
- `dst`  in  16  ALU result
- `Accum` 16, `Pcomp` 16, `Icomp` 12, `Pterm` 14, `Iterm` 12, `Fwd` 12, `A2D_res` 12, `Error` 12, `Intgrl` 12  out  registered ALU operands
- `src0sel`, `src1sel`  out  3  ALU source selects
- `multiply`, `sub`, `mult2`, `mult4`, `saturate`  out  1  ALU function flags; `mult4` is always 0
- `busy`  out  1  iteration in progress
- `done`  out  1  one-cycle pulse, `mtr_cmd` updated
- `mtr_cmd`  out  12  motor command, held between iterations

## Operation
- Reset: state IDLE; all registered outputs, `mtr_cmd`, the decimation counter and the saturation flag are 0. Outside ALU states, selects and flags are 0.
- States: IDLE -> CNV_REQ -> CNV_WAIT -> ERR -> INTG -> ICOMP -> PCOMP -> ACC1 -> ACC2 -> DONE -> IDLE.
- IDLE with `start`=1: latch `Accum`<={4'h0,setpoint}, `Pterm`, `Iterm`, `Fwd`; go to CNV_REQ.
- CNV_REQ: `strt_cnv`=1 for exactly one cycle.
- CNV_WAIT: hold until `cnv_cmplt`=1; on that edge `A2D_res`<=`a2d_in`.
- ALU steps. Format: src0/src1, flags -> write.
  - ERR: 000/000, `sub`, `saturate` -> `Error`<=dst[11:0]
  - INTG: 001/011, `saturate` -> `Intgrl`<=dst[11:0], only when decimation count == 3
  - ICOMP: 001/001, `multiply` -> `Icomp`<=dst[11:0]
  - PCOMP: 100/010, `multiply` -> `Pcomp`<=dst
  - ACC1: 011/100, `saturate` -> `Accum`<=dst
  - ACC2: 010/000, `mult2`, `saturate` -> `Accum`<=dst, `mtr_cmd`<=dst[11:0]
- Decimation counter: 2 bits, increments at the ACC2 edge, wraps 3->0.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored. No queuing.
- `cnv_cmplt` outside CNV_WAIT is ignored.
- `rst` in any state: IDLE, all zero, no `done` pulse.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycle 1: CNV_REQ, `strt_cnv`=1.
- From cycle 2: CNV_WAIT.
- With `cnv_cmplt`=1 at cycle n (n≥2): ERR n+1, INTG n+2, ICOMP n+3, PCOMP n+4, ACC1 n+5, ACC2 n+6, DONE n+7.
- `busy`=1 for cycles 1 through n+7.
- `mtr_cmd` changes at the ACC2 edge and is valid when `done`=1.
- Back-to-back: `start` held high is accepted again at cycle n+8.
- Each ALU step is one cycle. `dst` must be settled before the edge ending that state.

## Configuration
- `ANTI_WINDUP_EN` defined:
  - At the ACC2 edge, the saturation flag is set if dst[11:0] is 12'h7FF or 12'h800, and cleared otherwise.
  - While the flag is set, the INTG write is suppressed even when the count is 3.
  - The decimation counter still advances.
- `ANTI_WINDUP_EN` not defined: no flag exists; the INTG write depends only on the decimation count.

## Test plan
All cases use a bench stub that drives `dst` as a function of state.
- Reset mid-CNV_WAIT, then release -> all outputs 0, `busy`=0, no `done`; a new `start` is accepted one cycle later.
- `start` with `setpoint`=12'h100, `cnv_cmplt` 3 cycles after `strt_cnv`, `a2d_in`=12'h0AB -> `A2D_res`=12'h0AB; ERR shows `src0sel`=000, `src1sel`=000, `sub`=1, `saturate`=1; `done` at n+7.
- Stub `dst` per step: ERR 16'h0123, ICOMP 16'h0456, PCOMP 16'h1234, ACC1 16'h0200, ACC2 16'h0345 -> `Error`=12'h123, `Icomp`=12'h456, `Pcomp`=16'h1234, `mtr_cmd`=12'h345.
- Four iterations with stub INTG `dst`=16'h0011 -> `Intgrl` stays 0 for iterations 1-3 and becomes 12'h011 in iteration 4.
- `start` and stray `cnv_cmplt` pulses while busy -> no restart, no extra `strt_cnv`, `A2D_res` unchanged.
- With `ANTI_WINDUP_EN`: ACC2 `dst`=16'h07FF, then a fourth-iteration INTG -> `Intgrl` unchanged. Without the macro, the same stimulus writes `Intgrl`.
